// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : Shared constants for the AES SubBytes engine: datapath widths,
//               FSM state encoding, and the FIPS-197 forward S-box. The inverse
//               S-box is compiled in only when SUB_BYTES_INV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int WORD_W  = 32;
  localparam int ROUND_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef SUB_BYTES_INV_EN
  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage
`default_nettype wire

// File: rtl/sub_bytes_word.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes_word
// Description : Combinational S-box lookup on one 32-bit column (four
//               independent bytes). Inverse table selectable when the build
//               defines SUB_BYTES_INV_EN; otherwise inv_i is ignored.
// Ports       : word_i  [31:0] column in
//               inv_i          1 = inverse S-box (SUB_BYTES_INV_EN builds only)
//               word_o  [31:0] substituted column
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic              inv_i,
  output logic [WORD_W-1:0] word_o
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    logic [7:0] w_byte;
    assign w_byte = word_i[8*b +: 8];
`ifdef SUB_BYTES_INV_EN
    assign word_o[8*b +: 8] = inv_i ? SBOX_INV[w_byte] : SBOX_FWD[w_byte];
`else
    assign word_o[8*b +: 8] = SBOX_FWD[w_byte];
`endif
  end

`ifndef SUB_BYTES_INV_EN
  // Forward-only build: the select is tied off by the parent.
  logic w_unused_inv;
  assign w_unused_inv = inv_i;
`endif

endmodule
`default_nettype wire

// File: rtl/sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module      : sub_bytes_seq
// Description : Sequential AES SubBytes engine. Accepts a 128-bit state and a
//               round tag, substitutes LANES columns per cycle (4/LANES
//               passes), then presents the result until out_ready.
//               Optional macro SUB_BYTES_INV_EN adds inv_in to select the
//               inverse S-box per block.
// Ports       : clk, rst_n            clock, async active-low reset
//               in_valid / in_ready   input handshake
//               state_in [127:0]      state, column 0 = [127:96]
//               round_in [3:0]        tag passed through unchanged
//               inv_in                inverse select (SUB_BYTES_INV_EN only)
//               out_valid / out_ready output handshake
//               state_out [127:0]     substituted state
//               round_out [3:0]       tag of the result
// Parameters  : LANES (1, 2 or 4) columns substituted per cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  input  logic [ROUND_W-1:0] round_in,
`ifdef SUB_BYTES_INV_EN
  input  logic               inv_in,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic [ROUND_W-1:0] round_out
);

  // Column index of the final pass; col wraps to 0 naturally after it.
  localparam logic [1:0] LAST_COL = 2'(4 - LANES);

  state_e             state_q, state_d;
  logic [STATE_W-1:0] work_q, work_d;
  logic [ROUND_W-1:0] tag_q, tag_d;
  logic [1:0]         col_q, col_d;
  logic [STATE_W-1:0] sout_q, sout_d;
  logic [ROUND_W-1:0] rout_q, rout_d;
  logic               w_inv_sel;

`ifdef SUB_BYTES_INV_EN
  logic inv_q, inv_d;
  assign w_inv_sel = inv_q;
`else
  assign w_inv_sel = 1'b0;
`endif

  logic [1:0]        w_lane_col [LANES];
  logic [WORD_W-1:0] w_lane_in  [LANES];
  logic [WORD_W-1:0] w_lane_out [LANES];

  // Lane l works on column col+l; column 0 lives in the top word.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_col[l] = col_q + 2'(l);
    assign w_lane_in[l]  = work_q[WORD_W*(3 - int'(w_lane_col[l])) +: WORD_W];

    sub_bytes_word u_word (
      .word_i (w_lane_in[l]),
      .inv_i  (w_inv_sel),
      .word_o (w_lane_out[l])
    );
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    tag_d     = tag_q;
    col_d     = col_q;
    sout_d    = sout_q;
    rout_d    = rout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef SUB_BYTES_INV_EN
    inv_d     = inv_q;
`endif

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = state_in;
          tag_d   = round_in;
          col_d   = 2'd0;
          state_d = BUSY;
`ifdef SUB_BYTES_INV_EN
          inv_d   = inv_in;
`endif
        end
      end

      BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[WORD_W*(3 - int'(w_lane_col[l])) +: WORD_W] = w_lane_out[l];
        end
        col_d = col_q + 2'(LANES);
        if (col_q == LAST_COL) begin
          // Load the output registers with the fully substituted state so
          // the result is presented straight out of flops in DONE.
          sout_d  = work_d;
          rout_d  = tag_q;
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      tag_q   <= '0;
      col_q   <= 2'd0;
      sout_q  <= '0;
      rout_q  <= '0;
`ifdef SUB_BYTES_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      tag_q   <= tag_d;
      col_q   <= col_d;
      sout_q  <= sout_d;
      rout_q  <= rout_d;
`ifdef SUB_BYTES_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  assign state_out = sout_q;
  assign round_out = rout_q;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_bytes_seq
// Description : Self-checking bench for sub_bytes_seq. Three instances
//               (LANES = 1, 2, 4) share clock and reset. The S-box reference
//               is derived from GF(2^8) inversion plus the affine map; a
//               transaction scoreboard predicts in_ready/out_valid/data every
//               cycle for each instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_seq;

  localparam int N = 3;
  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [7:0] CORN_IN  [4] = '{8'h00, 8'h01, 8'h53, 8'hff};
  localparam logic [7:0] CORN_OUT [4] = '{8'h63, 8'h7c, 8'hed, 8'h16};

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid  [N];
  logic         in_ready  [N];
  logic [127:0] state_in  [N];
  logic [3:0]   round_in  [N];
  logic         out_valid [N];
  logic         out_ready [N];
  logic [127:0] state_out [N];
  logic [3:0]   round_out [N];
`ifdef SUB_BYTES_INV_EN
  logic         inv_in    [N];
`endif

  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_dut
    sub_bytes_seq #(.LANES(1 << k)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready[k]),
      .state_in  (state_in[k]),
      .round_in  (round_in[k]),
`ifdef SUB_BYTES_INV_EN
      .inv_in    (inv_in[k]),
`endif
      .out_valid (out_valid[k]),
      .out_ready (out_ready[k]),
      .state_out (state_out[k]),
      .round_out (round_out[k])
    );
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbf [256];
  logic [7:0] sbi [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_model();
    logic [7:0] iv;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      iv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) iv = 8'(b);
      end
      s = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^ {iv[4:0], iv[7:5]}
             ^ {iv[3:0], iv[7:4]} ^ 8'h63;
      sbf[a] = s;
      sbi[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] sub_state(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = inv ? sbi[s[8*i +: 8]] : sbf[s[8*i +: 8]];
    end
    return r;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [131:0] sbq [N][16];
  int wr [N];
  int rd [N];
  int acc_cyc [N];
  int n_out [N];
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic idle;
    logic exp_v;
    logic inv;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        wr[k] = 0;
        rd[k] = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idle  = (rd[k] == wr[k]);
        exp_v = !idle && (cyc >= acc_cyc[k] + (4 >> k));
        chk($sformatf("L%0d out_valid @%0d", 1 << k, cyc), 136'(out_valid[k]), 136'(exp_v));
        chk($sformatf("L%0d in_ready @%0d", 1 << k, cyc), 136'(in_ready[k]), 136'(idle));
        if (exp_v) begin
          chk($sformatf("L%0d result @%0d", 1 << k, cyc),
              {4'h0, round_out[k], state_out[k]}, {4'h0, sbq[k][rd[k] % 16]});
          if (out_ready[k]) begin
            rd[k]++;
            n_out[k]++;
          end
        end
        if (idle && in_valid[k]) begin
`ifdef SUB_BYTES_INV_EN
          inv = inv_in[k];
`else
          inv = 1'b0;
`endif
          sbq[k][wr[k] % 16] = {round_in[k], sub_state(state_in[k], inv)};
          wr[k]++;
          acc_cyc[k] = cyc + 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int k, input logic [127:0] s, input logic [3:0] r);
    int t;
    state_in[k] = s;
    round_in[k] = r;
    in_valid[k] = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready[k] && t < 100);
    if (!in_ready[k]) chk($sformatf("L%0d accept timeout", 1 << k), 136'(in_ready[k]), 136'(1));
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic expect_out(input int k, input logic [127:0] s, input logic [3:0] r,
                            input string name);
    int t;
    t = 0;
    while (!out_valid[k] && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("L%0d %s", 1 << k, name),
        {3'b000, out_valid[k], round_out[k], state_out[k]}, {4'b0001, r, s});
    @(posedge clk); #1;
  endtask

  task automatic stream(input int k);
    int sent;
    int base;
    int t;
    logic acc;
    sent = 0;
    base = n_out[k];
    t    = 0;
    while ((sent < 8 || in_valid[k] || n_out[k] < base + 8) && t < 3000) begin
      @(negedge clk);
      acc = in_valid[k] && in_ready[k];
      @(posedge clk); #1;
      t++;
      if (acc) begin
        in_valid[k] = 1'b0;
        sent++;
      end
      if (!in_valid[k] && sent < 8 && $urandom_range(0, 2) != 0) begin
        state_in[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
        round_in[k] = 4'($urandom_range(0, 15));
        in_valid[k] = 1'b1;
      end
      out_ready[k] = ($urandom_range(0, 2) != 0);
    end
    out_ready[k] = 1'b1;
    chk($sformatf("L%0d stream count", 1 << k), 136'(n_out[k] - base), 136'(8));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int k = 0; k < N; k++) begin
      in_valid[k]  = 1'b0;
      state_in[k]  = '0;
      round_in[k]  = '0;
      out_ready[k] = 1'b1;
      n_out[k]     = 0;
      acc_cyc[k]   = 0;
`ifdef SUB_BYTES_INV_EN
      inv_in[k]    = 1'b0;
`endif
    end
    build_model();

    // Pin the model to published values.
    chk("model fips", 136'(sub_state(FIPS_IN, 1'b0)), 136'(FIPS_OUT));
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("model byte %h", CORN_IN[c]), 136'(sbf[CORN_IN[c]]), 136'(CORN_OUT[c]));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("L%0d reset state", 1 << k),
          {2'b00, out_valid[k], in_ready[k], round_out[k], state_out[k]},
          {2'b00, 1'b0, 1'b1, 4'h0, 128'h0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 vector and byte corners on every lane width.
    for (int k = 0; k < N; k++) begin
      send(k, FIPS_IN, 4'd1);
      expect_out(k, FIPS_OUT, 4'd1, "fips");
      for (int c = 0; c < 4; c++) begin
        send(k, {16{CORN_IN[c]}}, 4'(c + 4));
        expect_out(k, {16{CORN_OUT[c]}}, 4'(c + 4), $sformatf("corner %h", CORN_IN[c]));
      end
    end

    // Backpressure on LANES=1.
    begin
      int t;
      out_ready[0] = 1'b0;
      send(0, FIPS_IN, 4'd7);
      t = 0;
      while (!out_valid[0] && t < 100) begin
        @(negedge clk);
        t++;
      end
      @(posedge clk); #1;
      state_in[0] = {16{8'h53}};
      round_in[0] = 4'd2;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk($sformatf("bp hold %0d", i),
            {2'b00, out_valid[0], in_ready[0], round_out[0], state_out[0]},
            {2'b00, 1'b1, 1'b0, 4'd7, FIPS_OUT});
      end
      @(posedge clk); #1;
      out_ready[0] = 1'b1;
      @(negedge clk);
      chk("bp no early accept", 136'(in_ready[0]), 136'(0));
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp ready after release", 136'(in_ready[0]), 136'(1));
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      expect_out(0, {16{8'hed}}, 4'd2, "bp next block");
    end

    // Reset two cycles into BUSY.
    send(0, FIPS_IN, 4'd9);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("L%0d mid-op reset", 1 << k),
          {2'b00, out_valid[k], in_ready[k], round_out[k], state_out[k]},
          {2'b00, 1'b0, 1'b1, 4'h0, 128'h0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, {16{8'h01}}, 4'd3);
    expect_out(0, {16{8'h7c}}, 4'd3, "after reset");

`ifdef SUB_BYTES_INV_EN
    for (int k = 0; k < N; k++) begin
      inv_in[k] = 1'b1;
      send(k, FIPS_OUT, 4'd5);
      expect_out(k, FIPS_IN, 4'd5, "inverse fips");
      send(k, {16{8'h63}}, 4'd6);
      expect_out(k, 128'h0, 4'd6, "inverse 63");
      inv_in[k] = 1'b0;
    end
`endif

    // Random stream with random downstream stalls.
    for (int k = 0; k < N; k++) begin
      stream(k);
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("L%0d drained", 1 << k), 136'(wr[k] - rd[k]), 136'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
